// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light safety monitor: lamp encodings,
// fault codes and the encoding legality helper.
package traffic_pkg;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   typedef enum logic [2:0] {
      FC_NONE      = 3'd0,
      FC_CONFLICT  = 3'd1,
      FC_ILLEGAL   = 3'd2,
      FC_BAD_SEQ   = 3'd3,
      FC_SHORT_YEL = 3'd4,
      FC_FM_OVR    = 3'd5
   } fault_code_e;

   function automatic logic is_legal_light(input logic [2:0] light);
      return (light == RED) || (light == YEL) || (light == GRN);
   endfunction

endpackage

// File: rtl/road_seq_checker.sv
// Per-road checker: flags illegal encodings, illegal colour transitions and
// yellows that end before MIN_YELLOW cycles. Holds the road's yellow counter.
module road_seq_checker
   import traffic_pkg::*;
#(
   parameter int MIN_YELLOW = 3,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] cur,
   input  logic [2:0] prev,
   input  logic       en,
   input  logic       clr,
   output logic       illegal,
   output logic       bad_seq,
   output logic       short_yel
);

   logic [CNT_W-1:0] yel_cnt;
   logic             seq_ok;

   // Legal transitions: stay on a colour, or advance R->G->Y->R.
   always_comb begin
      seq_ok = 1'b0;
      case ({prev, cur})
         {RED, RED}, {RED, GRN}, {GRN, GRN},
         {GRN, YEL}, {YEL, YEL}, {YEL, RED}: seq_ok = 1'b1;
         default:                            seq_ok = 1'b0;
      endcase
   end

   // Violation flags are raw; the top gates them with the fault state.
   always_comb begin
      illegal   = !is_legal_light(cur);
      bad_seq   = !illegal && !seq_ok;
      short_yel = (prev == YEL) && (cur == RED) && (yel_cnt < CNT_W'(MIN_YELLOW));
   end

   // Saturating count of consecutive yellow samples; frozen while disabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         yel_cnt <= '0;
      end else if (clr) begin
         yel_cnt <= '0;
      end else if (en) begin
         if (cur == YEL) begin
            if (yel_cnt != '1) yel_cnt <= yel_cnt + CNT_W'(1);
         end else begin
            yel_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor between the traffic light controller and the lamp drivers.
// Latches the first fault with a code and forces a fail-safe red on both
// roads while the fault is held. Optional macro FLASH_OUT_EN makes the
// fail-safe red flash with a half-period of FLASH_HALF cycles.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int MIN_YELLOW   = 3,
   parameter int FM_GREEN_MAX = 32,
   parameter int FLASH_HALF   = 4,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] light_HW,
   input  logic [2:0] light_FM,
   input  logic       fault_clear,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [2:0] safe_HW,
   output logic [2:0] safe_FM
);

   if ((FM_GREEN_MAX + 1) > (2**CNT_W - 1) || MIN_YELLOW > (2**CNT_W - 1) ||
       FLASH_HALF < 1 || (2 * FLASH_HALF) > 2**CNT_W) begin : g_cfg_check
      $error("traffic_light_monitor: CNT_W too narrow for the configured limits");
   end

   logic [2:0]       prev_hw, prev_fm;
   logic [CNT_W-1:0] fm_grn_cnt;
   logic             fault_q, fault_nxt;
   fault_code_e      code_q, code_nxt;
   logic             check_en;
   logic             hw_illegal, hw_bad_seq, hw_short_yel;
   logic             fm_illegal, fm_bad_seq, fm_short_yel;
   logic             conflict, fm_overrun;

   assign check_en = !fault_q;

   road_seq_checker #(.MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_hw_chk (
      .clk       (clk),
      .reset     (reset),
      .cur       (light_HW),
      .prev      (prev_hw),
      .en        (check_en),
      .clr       (fault_clear),
      .illegal   (hw_illegal),
      .bad_seq   (hw_bad_seq),
      .short_yel (hw_short_yel)
   );

   road_seq_checker #(.MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_fm_chk (
      .clk       (clk),
      .reset     (reset),
      .cur       (light_FM),
      .prev      (prev_fm),
      .en        (check_en),
      .clr       (fault_clear),
      .illegal   (fm_illegal),
      .bad_seq   (fm_bad_seq),
      .short_yel (fm_short_yel)
   );

   // Conflict is only judged between two legal encodings; overrun fires on
   // the green sample that would push the count past FM_GREEN_MAX.
   always_comb begin
      conflict   = !hw_illegal && !fm_illegal && (light_HW != RED) && (light_FM != RED);
      fm_overrun = (light_FM == GRN) && (fm_grn_cnt >= CNT_W'(FM_GREEN_MAX));
   end

   // Priority encode this cycle's violations; clear wins over any violation.
   always_comb begin
      code_nxt = FC_NONE;
      if (conflict)                          code_nxt = FC_CONFLICT;
      else if (hw_illegal || fm_illegal)     code_nxt = FC_ILLEGAL;
      else if (hw_bad_seq || fm_bad_seq)     code_nxt = FC_BAD_SEQ;
      else if (hw_short_yel || fm_short_yel) code_nxt = FC_SHORT_YEL;
      else if (fm_overrun)                   code_nxt = FC_FM_OVR;

      if (fault_clear)  fault_nxt = 1'b0;
      else if (fault_q) fault_nxt = 1'b1;
      else              fault_nxt = (code_nxt != FC_NONE);
   end

   // Sticky fault flag and first-fault code.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q <= 1'b0;
         code_q  <= FC_NONE;
      end else begin
         fault_q <= fault_nxt;
         if (fault_clear)                          code_q <= FC_NONE;
         else if (!fault_q && code_nxt != FC_NONE) code_q <= code_nxt;
      end
   end

   // Previous-sample registers and FM green counter; held while faulted.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_hw    <= RED;
         prev_fm    <= RED;
         fm_grn_cnt <= '0;
      end else if (fault_clear) begin
         prev_hw    <= light_HW;
         prev_fm    <= light_FM;
         fm_grn_cnt <= '0;
      end else if (check_en) begin
         prev_hw <= light_HW;
         prev_fm <= light_FM;
         if (light_FM == GRN) begin
            if (fm_grn_cnt != '1) fm_grn_cnt <= fm_grn_cnt + CNT_W'(1);
         end else begin
            fm_grn_cnt <= '0;
         end
      end
   end

`ifdef FLASH_OUT_EN
   logic [CNT_W-1:0] flash_cnt, flash_nxt;

   // Flash phase counts cycles since the fault rose, wrapping every full period.
   always_comb begin
      flash_nxt = '0;
      if (fault_nxt && fault_q) begin
         flash_nxt = (flash_cnt == CNT_W'(2 * FLASH_HALF - 1)) ? '0 : flash_cnt + CNT_W'(1);
      end
   end

   // Lamp drive: registered pass-through, or flashing red while faulted.
   always_ff @(posedge clk) begin
      if (reset) begin
         flash_cnt <= '0;
         safe_HW   <= RED;
         safe_FM   <= RED;
      end else begin
         flash_cnt <= flash_nxt;
         if (fault_nxt) begin
            safe_HW <= (flash_nxt < CNT_W'(FLASH_HALF)) ? RED : 3'b000;
            safe_FM <= (flash_nxt < CNT_W'(FLASH_HALF)) ? RED : 3'b000;
         end else begin
            safe_HW <= light_HW;
            safe_FM <= light_FM;
         end
      end
   end
`else
   // Lamp drive: registered pass-through, or steady red while faulted.
   always_ff @(posedge clk) begin
      if (reset) begin
         safe_HW <= RED;
         safe_FM <= RED;
      end else if (fault_nxt) begin
         safe_HW <= RED;
         safe_FM <= RED;
      end else begin
         safe_HW <= light_HW;
         safe_FM <= light_FM;
      end
   end
`endif

   assign fault      = fault_q;
   assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed scenarios followed by
// randomized controller-like traffic with injected faults, clears and resets.
module tb_traffic_light_monitor;

   localparam int MIN_YELLOW   = 3;
   localparam int FM_GREEN_MAX = 32;
   localparam int FLASH_HALF   = 4;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] light_HW = R;
   logic [2:0] light_FM = R;
   logic       fault_clear = 1'b0;
   logic       fault;
   logic [2:0] fault_code, safe_HW, safe_FM;

   traffic_light_monitor #(
      .MIN_YELLOW(MIN_YELLOW), .FM_GREEN_MAX(FM_GREEN_MAX),
      .FLASH_HALF(FLASH_HALF), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .light_HW(light_HW), .light_FM(light_FM),
      .fault_clear(fault_clear), .fault(fault), .fault_code(fault_code),
      .safe_HW(safe_HW), .safe_FM(safe_FM)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic       f;
      logic [2:0] code;
      logic [2:0] shw;
      logic [2:0] sfm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc++;

   // Reference model: remembered last colour, run lengths and fault status.
   bit         m_fault = 1'b0;
   int         m_code = 0;
   logic [2:0] m_last_hw = R, m_last_fm = R;
   int         m_yel_run_hw = 0, m_yel_run_fm = 0;
   int         m_fm_grn_run = 0;
   int         m_phase = 0;

   function automatic bit legal(input logic [2:0] x);
      return (x == R) || (x == Y) || (x == G);
   endfunction

   function automatic bit allowed(input logic [2:0] p, input logic [2:0] c);
      return (legal(c) && p == c) || (p == R && c == G) || (p == G && c == Y) || (p == Y && c == R);
   endfunction

   function automatic int classify(input logic [2:0] hw, input logic [2:0] fm);
      if (legal(hw) && legal(fm) && hw != R && fm != R) return 1;
      if (!legal(hw) || !legal(fm)) return 2;
      if (!allowed(m_last_hw, hw) || !allowed(m_last_fm, fm)) return 3;
      if ((m_last_hw == Y && hw == R && m_yel_run_hw < MIN_YELLOW) ||
          (m_last_fm == Y && fm == R && m_yel_run_fm < MIN_YELLOW)) return 4;
      if (fm == G && m_fm_grn_run + 1 > FM_GREEN_MAX) return 5;
      return 0;
   endfunction

   function automatic logic [2:0] fail_lamp(input int phase);
`ifdef FLASH_OUT_EN
      return (phase < FLASH_HALF) ? R : 3'b000;
`else
      return (phase >= 0) ? R : R;
`endif
   endfunction

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   // One clock of stimulus; the model's prediction goes into the scoreboard.
   task automatic step(input logic [2:0] hw, input logic [2:0] fm, input bit clr, input bit rst);
      exp_t e;
      int   v;
      @(posedge clk);
      #1;
      light_HW    = hw;
      light_FM    = fm;
      fault_clear = clr;
      reset       = rst;
      if (rst) begin
         m_fault = 0; m_code = 0; m_last_hw = R; m_last_fm = R;
         m_yel_run_hw = 0; m_yel_run_fm = 0; m_fm_grn_run = 0; m_phase = 0;
         e.shw = R; e.sfm = R;
      end else if (clr) begin
         m_fault = 0; m_code = 0; m_last_hw = hw; m_last_fm = fm;
         m_yel_run_hw = 0; m_yel_run_fm = 0; m_fm_grn_run = 0; m_phase = 0;
         e.shw = hw; e.sfm = fm;
      end else if (!m_fault) begin
         v = classify(hw, fm);
         m_yel_run_hw = (hw == Y) ? m_yel_run_hw + 1 : 0;
         m_yel_run_fm = (fm == Y) ? m_yel_run_fm + 1 : 0;
         m_fm_grn_run = (fm == G) ? m_fm_grn_run + 1 : 0;
         m_last_hw = hw;
         m_last_fm = fm;
         if (v != 0) begin
            m_fault = 1; m_code = v; m_phase = 0;
            e.shw = fail_lamp(0); e.sfm = fail_lamp(0);
         end else begin
            e.shw = hw; e.sfm = fm;
         end
      end else begin
         m_phase = (m_phase + 1) % (2 * FLASH_HALF);
         e.shw = fail_lamp(m_phase); e.sfm = fail_lamp(m_phase);
      end
      e.due  = cyc + 1;
      e.f    = m_fault;
      e.code = 3'(m_code);
      sb.push_back(e);
   endtask

   task automatic hold(input logic [2:0] hw, input logic [2:0] fm, input int n);
      for (int i = 0; i < n; i++) step(hw, fm, 1'b0, 1'b0);
   endtask

   // Random-traffic step: occasional garbage, clears while faulted, rare reset.
   task automatic rstep(input logic [2:0] hw, input logic [2:0] fm);
      logic [2:0] h, f;
      bit         c, r;
      h = hw; f = fm;
      c = m_fault && ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) begin
         h = 3'($urandom);
         f = 3'($urandom);
      end
      step(h, f, c, r);
   endtask

   task automatic rhold(input logic [2:0] hw, input logic [2:0] fm, input int n);
      for (int i = 0; i < n; i++) rstep(hw, fm);
   endtask

   // Monitor: pops each prediction on the cycle it is due and compares.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_late: entry due %0d seen at %0d", e.due, cyc);
            end else begin
               check("fault", {2'b00, fault}, {2'b00, e.f});
               check("fault_code", fault_code, e.code);
               check("safe_HW", safe_HW, e.shw);
               check("safe_FM", safe_FM, e.sfm);
            end
         end
      end
   end

   initial begin
      int wait_cnt;
      step(R, R, 1'b0, 1'b1);
      hold(R, R, 3);
      // legal full cycle
      hold(G, R, 10); hold(Y, R, 3); hold(R, R, 1);
      hold(R, G, 5);  hold(R, Y, 3); hold(R, R, 1);
      hold(G, R, 2);  hold(Y, R, 3); hold(R, R, 2);
      // conflicting greens, then clear
      step(G, G, 1'b0, 1'b0); hold(R, R, 3);
      step(R, R, 1'b1, 1'b0); hold(R, R, 2);
      // short yellow, then clear
      hold(G, R, 2); hold(Y, R, 2); step(R, R, 1'b0, 1'b0); hold(R, R, 2);
      step(R, R, 1'b1, 1'b0); hold(R, R, 1);
      // FM green exactly at the limit, then one over
      hold(R, G, FM_GREEN_MAX); hold(R, Y, 3); hold(R, R, 2);
      hold(R, G, FM_GREEN_MAX + 1); hold(R, R, 2);
      step(R, R, 1'b1, 1'b0); hold(R, R, 1);
      // illegal encoding beats conflict
      step(3'b011, G, 1'b0, 1'b0); hold(R, R, 2);
      step(R, R, 1'b1, 1'b0);
      // direct G->R
      hold(G, R, 2); step(R, R, 1'b0, 1'b0); hold(R, R, 2);
      // reset while faulted
      step(R, R, 1'b0, 1'b1); hold(R, R, 2);
      // long fault hold to show the fail-safe pattern
      step(G, G, 1'b0, 1'b0); hold(R, R, 20);
      step(R, R, 1'b1, 1'b0); hold(R, R, 2);
      // randomized controller-like traffic
      for (int k = 0; k < 30; k++) begin
         rhold(G, R, $urandom_range(1, 12));
         rhold(Y, R, $urandom_range(1, 4));
         rhold(R, R, 1);
         rhold(R, G, $urandom_range(1, 36));
         rhold(R, Y, $urandom_range(1, 4));
         rhold(R, R, $urandom_range(1, 2));
         if (m_fault) step(R, R, 1'b1, 1'b0);
      end
      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
